// File: rtl/banked_mem_ctrl.sv
// Multi-bank burst backing memory: 32-byte lines moved as BURST_LEN beats, one bank per line address.
// Latency: read data starts READ_LATENCY cycles after accept; a bank stays busy WRITE_LATENCY cycles after its last write beat.
// Backpressure: bmem_ready drops while a write burst is in flight or the target bank is busy; requester holds until accepted.
//
// Ports: clk/rst (async, active-high); request side bmem_addr/bmem_read/bmem_write/bmem_wdata/bmem_ready;
// response side bmem_raddr/bmem_rdata/bmem_rvalid (zero when not valid); error (sticky protocol error).
// Optional macro BMEM_PROTO_CHECK_EN: enables protocol checking on error and rejects read&write in one cycle.
module banked_mem_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 64,
    parameter int BURST_LEN      = 4,
    parameter int NUM_BANKS      = 4,
    parameter int LINES_PER_BANK = 64,
    parameter int READ_LATENCY   = 8,
    parameter int WRITE_LATENCY  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bmem_addr,
    input  logic                  bmem_read,
    input  logic                  bmem_write,
    input  logic [DATA_WIDTH-1:0] bmem_wdata,
    output logic                  bmem_ready,
    output logic [ADDR_WIDTH-1:0] bmem_raddr,
    output logic [DATA_WIDTH-1:0] bmem_rdata,
    output logic                  bmem_rvalid,
    output logic                  error
);
    localparam int OFS_BITS  = $clog2(BURST_LEN * DATA_WIDTH / 8);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int LINE_BITS = $clog2(LINES_PER_BANK);
    localparam int BEAT_BITS = $clog2(BURST_LEN);
    localparam int IDX_BITS  = BANK_BITS + LINE_BITS + BEAT_BITS;
    localparam int MAX_LAT   = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int TMR_BITS  = $clog2(MAX_LAT + 1);

    localparam logic [BEAT_BITS-1:0] LAST_BEAT   = BEAT_BITS'(BURST_LEN - 1);
    // Timer reaches zero in the cycle before the first beat, so the arbiter can launch on that edge.
    localparam logic [TMR_BITS-1:0]  RD_TMR_INIT = TMR_BITS'(READ_LATENCY - 2);
    localparam logic [TMR_BITS-1:0]  WR_TMR_INIT = TMR_BITS'((WRITE_LATENCY > 0) ? WRITE_LATENCY - 1 : 0);

    typedef enum logic [2:0] {
        BK_IDLE,
        BK_RD_WAIT,   // counting down latency, then eligible for the response port
        BK_RD_RESP,   // owns the response port
        BK_WR,        // receiving write beats
        BK_WR_COOL    // post-write busy time
    } bank_state_t;

    bank_state_t           bank_state [NUM_BANKS];
    logic [TMR_BITS-1:0]   bank_tmr   [NUM_BANKS];
    logic [ADDR_WIDTH-1:0] bank_addr  [NUM_BANKS];

    logic                  wr_active;
    logic [BEAT_BITS-1:0]  wr_beat;
    logic [BANK_BITS-1:0]  wr_bank;
    logic [LINE_BITS-1:0]  wr_line;

    logic                  resp_active;
    logic [BANK_BITS-1:0]  resp_bank;
    logic [BEAT_BITS-1:0]  resp_beat;
    logic [ADDR_WIDTH-1:0] resp_addr;

    logic [DATA_WIDTH-1:0] mem [0:(1<<IDX_BITS)-1];

    logic [BANK_BITS-1:0]  req_bank;
    logic [LINE_BITS-1:0]  req_line;
    logic                  rw_conflict;
    logic                  acc_wr;
    logic                  acc_rd;
    logic                  arb_vld;
    logic [BANK_BITS-1:0]  arb_bank;
    logic                  resp_last;
    logic                  launch;

    assign req_bank = bmem_addr[OFS_BITS +: BANK_BITS];
    assign req_line = bmem_addr[OFS_BITS + BANK_BITS +: LINE_BITS];

`ifdef BMEM_PROTO_CHECK_EN
    assign rw_conflict = bmem_read & bmem_write;
`else
    assign rw_conflict = 1'b0;
`endif

    assign bmem_ready = !rst && !wr_active && (bank_state[req_bank] == BK_IDLE) && !rw_conflict;
    // read&write together counts as a write when it is not rejected as a conflict
    assign acc_wr = bmem_write & bmem_ready;
    assign acc_rd = bmem_read & ~bmem_write & bmem_ready;

    // Fixed priority: lowest eligible bank index wins the response port.
    always_comb begin
        arb_vld  = 1'b0;
        arb_bank = '0;
        for (int b = NUM_BANKS - 1; b >= 0; b--) begin
            if (bank_state[b] == BK_RD_WAIT && bank_tmr[b] == '0) begin
                arb_vld  = 1'b1;
                arb_bank = BANK_BITS'(b);
            end
        end
    end

    assign resp_last = resp_active && (resp_beat == LAST_BEAT);
    // A new burst may follow the previous one with no gap, but never cuts it short.
    assign launch    = arb_vld && (!resp_active || resp_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state[b] <= BK_IDLE;
                bank_tmr[b]   <= '0;
                bank_addr[b]  <= '0;
            end
            wr_active   <= 1'b0;
            wr_beat     <= '0;
            wr_bank     <= '0;
            wr_line     <= '0;
            resp_active <= 1'b0;
            resp_bank   <= '0;
            resp_beat   <= '0;
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                case (bank_state[b])
                    BK_IDLE: begin
                        if (req_bank == BANK_BITS'(b)) begin
                            if (acc_wr) begin
                                bank_state[b] <= BK_WR;
                            end else if (acc_rd) begin
                                bank_state[b] <= BK_RD_WAIT;
                                bank_tmr[b]   <= RD_TMR_INIT;
                                bank_addr[b]  <= bmem_addr;
                            end
                        end
                    end
                    BK_RD_WAIT: begin
                        if (bank_tmr[b] != '0) bank_tmr[b] <= bank_tmr[b] - 1'b1;
                        if (launch && arb_bank == BANK_BITS'(b)) bank_state[b] <= BK_RD_RESP;
                    end
                    BK_RD_RESP: begin
                        if (resp_last && resp_bank == BANK_BITS'(b)) bank_state[b] <= BK_IDLE;
                    end
                    BK_WR: begin
                        if (wr_beat == LAST_BEAT) begin
                            if (WRITE_LATENCY == 0) begin
                                bank_state[b] <= BK_IDLE;
                            end else begin
                                bank_state[b] <= BK_WR_COOL;
                                bank_tmr[b]   <= WR_TMR_INIT;
                            end
                        end
                    end
                    BK_WR_COOL: begin
                        if (bank_tmr[b] == '0) bank_state[b] <= BK_IDLE;
                        else                   bank_tmr[b]   <= bank_tmr[b] - 1'b1;
                    end
                    default: bank_state[b] <= BK_IDLE;
                endcase
            end

            // Follow-on beats are captured whether or not bmem_write is held.
            if (acc_wr) begin
                wr_active <= 1'b1;
                wr_beat   <= BEAT_BITS'(1);
                wr_bank   <= req_bank;
                wr_line   <= req_line;
            end else if (wr_active) begin
                wr_beat <= wr_beat + 1'b1;
                if (wr_beat == LAST_BEAT) wr_active <= 1'b0;
            end

            if (launch) begin
                resp_active <= 1'b1;
                resp_bank   <= arb_bank;
                resp_beat   <= '0;
            end else if (resp_last) begin
                resp_active <= 1'b0;
            end else if (resp_active) begin
                resp_beat <= resp_beat + 1'b1;
            end
        end
    end

    // Storage is not reset; each beat is committed on the edge that captures it.
    always_ff @(posedge clk) begin
        if (acc_wr)
            mem[{req_bank, req_line, {BEAT_BITS{1'b0}}}] <= bmem_wdata;
        else if (wr_active)
            mem[{wr_bank, wr_line, wr_beat}] <= bmem_wdata;
    end

    assign resp_addr   = bank_addr[resp_bank];
    assign bmem_rvalid = resp_active;
    assign bmem_raddr  = resp_active ? resp_addr : '0;
    assign bmem_rdata  = resp_active ? mem[{resp_bank, resp_addr[OFS_BITS + BANK_BITS +: LINE_BITS], resp_beat}] : '0;

`ifdef BMEM_PROTO_CHECK_EN
    logic err_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_q <= 1'b0;
        else if (rw_conflict ||
                 ((acc_rd | acc_wr) && bmem_addr[OFS_BITS-1:0] != '0) ||
                 (wr_active && !bmem_write))
            err_q <= 1'b1;
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// Testbench for banked_mem_ctrl: directed scenarios plus random traffic against a timestamp-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// Model tracks per-bank free times, pending reads and the shared response port in cycle numbers.
module tb_banked_mem_ctrl;
    localparam int RL  = 8;
    localparam int WL  = 4;
    localparam int BL  = 4;
    localparam int BIG = 1 << 30;

    logic        clk;
    logic        rst;
    logic [31:0] bmem_addr;
    logic        bmem_read;
    logic        bmem_write;
    logic [63:0] bmem_wdata;
    logic        bmem_ready;
    logic [31:0] bmem_raddr;
    logic [63:0] bmem_rdata;
    logic        bmem_rvalid;
    logic        error;

    banked_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .bmem_addr  (bmem_addr),
        .bmem_read  (bmem_read),
        .bmem_write (bmem_write),
        .bmem_wdata (bmem_wdata),
        .bmem_ready (bmem_ready),
        .bmem_raddr (bmem_raddr),
        .bmem_rdata (bmem_rdata),
        .bmem_rvalid(bmem_rvalid),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  addr;
        logic [1:0]   bank;
        logic [31:0]  acc;
        logic [255:0] data;
    } rd_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [31:0] addr;
        logic [63:0] data;
    } obs_t;

    // reference model state
    logic [63:0] m_mem [int];
    rd_t         m_pend [$];
    rd_t         m_cur;
    int          m_cur_start;
    int          m_port_free;
    int          m_bank_free [4];
    int          m_wr_start;
    int          m_wr_until;
    logic [31:0] m_wr_addr;
    logic        m_err;
    logic        m_acc;
    int          cyc = 0;

    // observed outputs
    logic        obs_ready, obs_rvalid, obs_err;
    logic [31:0] obs_raddr;
    logic [63:0] obs_rdata;
    obs_t        obs_q [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int key(input logic [31:0] a, input int beat);
        return int'(a[12:5]) * 4 + beat;
    endfunction

    function automatic int first_cyc(input logic [31:0] a);
        foreach (obs_q[i]) if (obs_q[i].addr == a) return int'(obs_q[i].cyc);
        return -1;
    endfunction

    // One clock cycle: drive, sample, compare against the model, then advance the model.
    task automatic step(input logic rd, input logic wr, input logic [31:0] addr, input logic [63:0] wd);
        int   sel, bi, b;
        logic exp_rdy;
        rd_t  e;
        @(posedge clk);
        #1;
        bmem_read  = rd;
        bmem_write = wr;
        bmem_addr  = addr;
        bmem_wdata = wd;
        #5;
        obs_ready  = bmem_ready;
        obs_rvalid = bmem_rvalid;
        obs_raddr  = bmem_raddr;
        obs_rdata  = bmem_rdata;
        obs_err    = error;
        if (obs_rvalid) obs_q.push_back({32'(cyc), obs_raddr, obs_rdata});

        if (cyc >= m_port_free) begin
            sel = -1;
            foreach (m_pend[i])
                if (int'(m_pend[i].acc) + RL <= cyc && (sel < 0 || m_pend[i].bank < m_pend[sel].bank))
                    sel = i;
            if (sel >= 0) begin
                m_cur       = m_pend[sel];
                m_pend.delete(sel);
                m_cur_start = cyc;
                m_port_free = cyc + BL;
                m_bank_free[m_cur.bank] = cyc + BL;
            end
        end
        if (cyc < m_port_free) begin
            bi = cyc - m_cur_start;
            check("rvalid", 64'(obs_rvalid), 64'd1);
            check("raddr", 64'(obs_raddr), 64'(m_cur.addr));
            check("rdata", obs_rdata, m_cur.data[bi*64 +: 64]);
        end else begin
            check("rvalid", 64'(obs_rvalid), 64'd0);
            check("raddr_idle", 64'(obs_raddr), 64'd0);
            check("rdata_idle", obs_rdata, 64'd0);
        end

        b = int'(addr[6:5]);
        exp_rdy = (cyc > m_wr_until) && (cyc >= m_bank_free[b]);
`ifdef BMEM_PROTO_CHECK_EN
        if (rd && wr) exp_rdy = 1'b0;
`endif
        check("ready", 64'(obs_ready), 64'(exp_rdy));
        check("error", 64'(obs_err), 64'(m_err));

        m_acc = exp_rdy && (rd || wr);
`ifdef BMEM_PROTO_CHECK_EN
        if (rd && wr) m_err = 1'b1;
        if (m_acc && addr[4:0] != 5'd0) m_err = 1'b1;
        if (!m_acc && cyc <= m_wr_until && !wr) m_err = 1'b1;
`endif
        if (m_acc && wr) begin
            m_wr_start = cyc;
            m_wr_until = cyc + BL - 1;
            m_wr_addr  = addr;
            m_bank_free[b] = cyc + BL + WL;
            m_mem[key(addr, 0)] = wd;
        end else if (m_acc) begin
            e.addr = addr;
            e.bank = addr[6:5];
            e.acc  = 32'(cyc);
            for (int k = 0; k < BL; k++)
                e.data[k*64 +: 64] = m_mem.exists(key(addr, k)) ? m_mem[key(addr, k)] : 64'bx;
            m_pend.push_back(e);
            m_bank_free[b] = BIG;
        end else if (cyc <= m_wr_until) begin
            m_mem[key(m_wr_addr, cyc - m_wr_start)] = wd;
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 64'h0);
    endtask

    // Holds a request until the model sees it accepted; writes then send their follow-on beats.
    task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                          input logic [255:0] beats, output int acc_cyc);
        int n;
        n = 0;
        acc_cyc = -1;
        while (acc_cyc < 0 && n < 200) begin
            step(rd, wr, addr, beats[63:0]);
            if (m_acc) acc_cyc = cyc - 1;
            n++;
        end
        if (acc_cyc < 0) check("req_timeout", 64'd0, 64'd1);
        else if (wr)
            for (int k = 1; k < BL; k++) step(1'b0, 1'b1, addr, beats[k*64 +: 64]);
    endtask

    task automatic do_reset(input int ncyc);
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bmem_read  = 1'b0;
        bmem_write = 1'b0;
        bmem_addr  = 32'h0;
        bmem_wdata = 64'h0;
        #1;
        check("rst_ready", 64'(bmem_ready), 64'd0);
        check("rst_rvalid", 64'(bmem_rvalid), 64'd0);
        check("rst_rdata", bmem_rdata, 64'd0);
        check("rst_raddr", 64'(bmem_raddr), 64'd0);
        check("rst_error", 64'(error), 64'd0);
        repeat (ncyc) @(posedge clk);
        #1;
        rst = 1'b0;
        m_pend.delete();
        m_port_free = 0;
        for (int i = 0; i < 4; i++) m_bank_free[i] = 0;
        m_wr_until = -1;
        m_wr_start = 0;
        m_err      = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          t;
        logic [255:0] bt;
        logic        h_have, h_rd, h_wr;
        logic [31:0] h_addr;
        int          r;

        rst = 1'b1;
        bmem_read = 1'b0; bmem_write = 1'b0; bmem_addr = 32'h0; bmem_wdata = 64'h0;
        do_reset(3);

        // idle after reset
        idle(1);
        check("idle_ready", 64'(obs_ready), 64'd1);
        check("idle_rvalid", 64'(obs_rvalid), 64'd0);

        // write 0x40 then read it back
        bt = {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}};
        do_req(1'b0, 1'b1, 32'h40, bt, t);
        do_req(1'b0, 1'b1, 32'h00, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, t);
        do_req(1'b0, 1'b1, 32'h20, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, t);
        do_req(1'b0, 1'b1, 32'h60, {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom}, t);
        idle(12);
        obs_q.delete();
        do_req(1'b1, 1'b0, 32'h40, 256'h0, t);
        idle(14);
        check("t1_len", 64'(obs_q.size()), 64'd4);
        for (int k = 0; k < 4 && k < obs_q.size(); k++) begin
            check("t1_cyc", 64'(int'(obs_q[k].cyc) - t), 64'(RL + k));
            check("t1_addr", 64'(obs_q[k].addr), 64'h40);
            check("t1_data", obs_q[k].data, bt[k*64 +: 64]);
        end

        // bank 1 then bank 2: second waits for the port; bank 1 busy
        idle(12);
        obs_q.delete();
        do_req(1'b1, 1'b0, 32'h20, 256'h0, t);
        step(1'b1, 1'b0, 32'h40, 64'h0);
        check("t2_acc_b2", 64'(obs_ready), 64'd1);
        step(1'b1, 1'b0, 32'h20, 64'h0);
        check("t2_b1_busy", 64'(obs_ready), 64'd0);
        idle(20);
        check("t2_b1_start", 64'(first_cyc(32'h20) - t), 64'd8);
        check("t2_b2_start", 64'(first_cyc(32'h40) - t), 64'd12);

        // banks 3 and 1 eligible together while bank 0 holds the port
        idle(12);
        obs_q.delete();
        do_req(1'b1, 1'b0, 32'h00, 256'h0, t);
        step(1'b1, 1'b0, 32'h60, 64'h0);
        step(1'b1, 1'b0, 32'h20, 64'h0);
        idle(24);
        check("t3_b0_start", 64'(first_cyc(32'h00) - t), 64'd8);
        check("t3_b1_first", 64'(first_cyc(32'h20) - t), 64'd12);
        check("t3_b3_second", 64'(first_cyc(32'h60) - t), 64'd16);

        // reset during read latency drops the response
        idle(12);
        obs_q.delete();
        do_req(1'b1, 1'b0, 32'h40, 256'h0, t);
        idle(3);
        do_reset(2);
        idle(15);
        check("t4_no_burst", 64'(obs_q.size()), 64'd0);
        check("t4_ready", 64'(obs_ready), 64'd1);

`ifdef BMEM_PROTO_CHECK_EN
        idle(2);
        step(1'b1, 1'b1, 32'h80, 64'h0);
        check("t5_not_acc", 64'(obs_ready), 64'd0);
        idle(3);
        check("t5_err", 64'(obs_err), 64'd1);
        do_reset(2);
        idle(2);
        check("t5_err_clr", 64'(obs_err), 64'd0);
`endif

        // random traffic with aliased upper address bits
        h_have = 1'b0; h_rd = 1'b0; h_wr = 1'b0; h_addr = 32'h0;
        for (int i = 0; i < 1500; i++) begin
            if (cyc <= m_wr_until) begin
                step(1'b0, 1'b1, m_wr_addr, {$urandom, $urandom});
            end else begin
                if (!h_have) begin
                    r = $urandom_range(0, 9);
                    h_addr = $urandom;
                    h_addr[12:7] = 6'($urandom_range(0, 3));
                    h_addr[4:0]  = 5'd0;
                    h_rd = (r >= 3 && r <= 6);
                    h_wr = (r >= 7);
                    if (h_rd && !m_mem.exists(key(h_addr, 3))) begin
                        h_rd = 1'b0;
                        h_wr = 1'b1;
                    end
                    h_have = h_rd || h_wr;
                end
                if (h_have) begin
                    step(h_rd, h_wr, h_addr, {$urandom, $urandom});
                    if (m_acc) h_have = 1'b0;
                end else begin
                    step(1'b0, 1'b0, 32'h0, 64'h0);
                end
            end
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/banked_mem_ctrl.md
Name: banked_mem_ctrl

Overview:
- Synthesizable multi-bank, burst-oriented backing memory behind the CPU's single `bmem_*` port (cache-line refill/writeback path, below the caches).
- Accepts 32-byte line requests as 4 x 64-bit beats.
- Services each request in the bank selected by the address.
- Returns read bursts tagged with their address, so completion order may differ from issue order.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 64, bits per beat.
- BURST_LEN, 4, beats per line (line = 32 bytes).
- NUM_BANKS, 4, banks (power of 2).
- LINES_PER_BANK, 64, storage lines per bank (power of 2).
- READ_LATENCY, 8, cycles from read accept to first response beat (>=2).
- WRITE_LATENCY, 4, cycles a bank stays busy after the last write beat.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset; asynchronous, active-high.
- bmem_addr, in, ADDR_WIDTH, line-aligned request byte address.
- bmem_read, in, 1, read request.
- bmem_write, in, 1, write request/beat valid.
- bmem_wdata, in, DATA_WIDTH, write beat data.
- bmem_ready, out, 1, request accepted this cycle if read|write.
- bmem_raddr, out, ADDR_WIDTH, address of the line being returned.
- bmem_rdata, out, DATA_WIDTH, read beat data.
- bmem_rvalid, out, 1, read beat valid.
- error, out, 1, sticky protocol error.

Behaviour:
- Address decode:
  - bank = addr[5 +: log2(NUM_BANKS)].
  - line = next log2(LINES_PER_BANK) bits.
  - Upper bits ignored; addresses alias/wrap.
- Beat order: beat k holds bytes [8k+7:8k] of the line, k=0..3.
- bmem_ready (combinational) is 1 iff all of:
  - not in reset;
  - no write burst in progress;
  - the target bank is idle.
- Accept = (bmem_read|bmem_write) & bmem_ready. Requests seen while ready=0 are ignored; the requester holds until accepted.
- Read:
  - Accept at cycle T marks the bank busy and latches the address.
  - At T+READ_LATENCY the bank becomes response-eligible.
  - Response: BURST_LEN consecutive cycles with rvalid=1, raddr=latched address, rdata=beats 0..3.
- Response port is shared. When several banks are eligible, the lowest bank index wins. A burst, once started, is never interrupted. Losing banks stay busy and wait.
- Write:
  - Beat 0 is taken with the accept.
  - Beats 1..3 are captured on the next 3 cycles; bmem_write must be held high with the data, and ready=0 during them.
  - Missing write on a follow-on beat: the beat is still captured and error is set.
  - After the last beat the bank is busy WRITE_LATENCY cycles.
- Ordering and hazards:
  - Write data is committed to storage beat by beat.
  - A read accepted later always returns the new data.
  - Responses to different banks may return out of issue order.
  - Same bank is serialized by the busy flag.
- Simultaneous events:
  - A new request may be accepted in the same cycle a response beat is driven.
  - A write burst does not block read responses.
  - Read accepted to a bank becomes eligible no earlier than READ_LATENCY cycles.
- When rvalid=0, rdata and raddr are 0.
- Reset:
  - Asynchronous; clears all bank busy/timers, any in-flight write burst, any pending/active response, and error.
  - Outputs while in reset: bmem_ready=0, bmem_rvalid=0, bmem_rdata=0, bmem_raddr=0, error=0.
  - Reset mid-burst drops the burst; partially written beats remain in storage.
  - Storage array contents are not reset; uninitialized reads return X in simulation.

Optional Feature:
BMEM_PROTO_CHECK_EN
- Defined:
  - error is set (sticky until reset) on bmem_read&bmem_write in the same cycle; that request is not accepted and ready is forced 0 that cycle.
  - error is also set on an accepted addr[4:0]!=0 (low bits ignored) and on a dropped follow-on write beat.
- Undefined:
  - error is tied 0.
  - read&write together is treated as a write.
  - Misalignment is silently ignored.

Test Plan:
- Reset then idle -> ready=1, rvalid=0, rdata=0, raddr=0, error=0.
- Write 0x00000040 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44; later read 0x00000040 -> rvalid exactly 4 cycles, starting 8 cycles after read accept, beats in order, raddr=0x40.
- Read 0x00000020 (bank 1) at T, read 0x00000040 (bank 2) at T+1 -> bank1 burst T+8..T+11, bank2 burst T+12..T+15 (arbitration wait); second read to bank 1 at T+2 sees ready=0.
- Two banks eligible in the same cycle (reads to 0x60 and 0x20 in the same eligibility window) -> bank 1 (0x20) returned first.
- rst asserted during a read's latency -> outputs 0 immediately, no burst afterwards, ready=1 after release.
- With BMEM_PROTO_CHECK_EN: read=write=1 at 0x80 -> not accepted, error=1 until rst.
